// File: rtl/ghost_ai_controller.sv
// ghost_ai_controller
// Shared, time-multiplexed direction engine for up to eight ghosts, plus
// the global SCATTER / CHASE / FRIGHTENED mode sequencer.
//
// Each frame_tick starts a sweep while the engine is idle. During a sweep,
// one ghost is evaluated per cycle, in order 0 .. NUM_GHOSTS-1. The ghost's
// direction register is written at the end of its evaluation cycle. After
// the last ghost, sweep_done pulses for one cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   frame_tick      one-cycle pulse per game frame (advances mode timer, starts sweep)
//   power_pellet    one-cycle pulse, enters / re-arms FRIGHTENED
//   pacman_pos_x/y  pacman position (CHASE target)
//   ghost_pos_x/y   packed ghost positions, ghost i at slice i
//   valid_moves     packed per-ghost legal directions, 4 bits per ghost
//   move_direction  packed registered one-hot directions, 4 bits per ghost
//   mode            00 SCATTER, 01 CHASE, 10 FRIGHTENED
//   busy            sweep in progress
//   sweep_done      one-cycle pulse after the last ghost is written
//   overrun         sticky, frame_tick seen while busy
module ghost_ai_controller #(
    parameter int NUM_GHOSTS     = 4,
    parameter int X_W            = 11,
    parameter int Y_W            = 10,
    parameter int MAX_X          = 639,
    parameter int MAX_Y          = 479,
    parameter int SCATTER_FRAMES = 420,
    parameter int CHASE_FRAMES   = 1200,
    parameter int FRIGHT_FRAMES  = 360,
    parameter int TMR_W          = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    power_pellet,
    input  logic [X_W-1:0]          pacman_pos_x,
    input  logic [Y_W-1:0]          pacman_pos_y,
    input  logic [NUM_GHOSTS*X_W-1:0] ghost_pos_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] ghost_pos_y,
    input  logic [NUM_GHOSTS*4-1:0] valid_moves,
    output logic [NUM_GHOSTS*4-1:0] move_direction,
    output logic [1:0]              mode,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    overrun
);

    // Common signed width for both axes, with one guard bit for the sign.
    localparam int DW = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam logic [2:0] LAST_IDX = 3'(NUM_GHOSTS - 1);

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    localparam logic [TMR_W-1:0] SCAT_LAST   = TMR_W'(SCATTER_FRAMES - 1);
    localparam logic [TMR_W-1:0] CHASE_LAST  = TMR_W'(CHASE_FRAMES - 1);
    localparam logic [TMR_W-1:0] FRIGHT_LAST = TMR_W'(FRIGHT_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'b00,
        MODE_CHASE   = 2'b01,
        MODE_FRIGHT  = 2'b10
    } mode_e;

    // Opposite heading: the bit order RIGHT,UP,DOWN,LEFT mirrors onto itself.
    function automatic logic [3:0] reverse_dir(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    // Frightened rotation slots: UP, LEFT, DOWN, RIGHT.
    function automatic logic [3:0] slot_dir(input logic [1:0] s);
        logic [3:0] d;
        case (s)
            2'd0:    d = DIR_UP;
            2'd1:    d = DIR_LEFT;
            2'd2:    d = DIR_DOWN;
            2'd3:    d = DIR_RIGHT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

    // First allowed direction rotating from the pseudo-random start slot.
    // Walk backwards so the lowest rotation offset is written last and wins.
    function automatic logic [3:0] fright_pick(input logic [3:0] allowed,
                                               input logic [1:0] start);
        logic [3:0] res;
        logic [3:0] d;
        res = 4'b0000;
        for (int k = 3; k >= 0; k--) begin
            d   = slot_dir(start + 2'(k));
            res = ((allowed & d) != 4'b0000) ? d : res;
        end
        return res;
    endfunction

    // Target pursuit: primary axis, secondary axis, then fixed fallback order.
    // A zero-distance axis contributes 4'b0000 and so never matches.
    function automatic logic [3:0] target_pick(input logic [3:0] allowed,
                                               input logic [3:0] prim,
                                               input logic [3:0] sec);
        logic [3:0] res;
        if ((allowed & prim) != 4'b0000) begin
            res = prim;
        end else if ((allowed & sec) != 4'b0000) begin
            res = sec;
        end else if (allowed[1]) begin
            res = DIR_UP;
        end else if (allowed[3]) begin
            res = DIR_LEFT;
        end else if (allowed[2]) begin
            res = DIR_DOWN;
        end else begin
            res = DIR_RIGHT;
        end
        return res;
    endfunction

    mode_e            mode_r, mode_nxt_s, saved_mode_r, saved_mode_nxt_s;
    logic [TMR_W-1:0] tmr_r, tmr_nxt_s, saved_tmr_r, saved_tmr_nxt_s;
    logic             mode_change_s;

    logic [2:0]            idx_r;
    logic [15:0]           lfsr_r;
    logic [NUM_GHOSTS-1:0] rev_pend_r;

    logic [X_W-1:0]        cur_gx_s, tx_s;
    logic [Y_W-1:0]        cur_gy_s, ty_s;
    logic [3:0]            cur_v_s, cur_p_s, rev_s, allowed_s;
    logic                  cur_rp_s;
    logic signed [DW-1:0]  dx_s, dy_s;
    logic [DW-1:0]         adx_s, ady_s;
    logic [3:0]            dir_x_s, dir_y_s, prim_s, sec_s;
    logic [3:0]            next_dir_s;
    logic                  clear_rp_s;

    assign mode = mode_r;

    // Mode sequencer next state: pellet has priority over the frame timer.
    always_comb begin
        mode_nxt_s       = mode_r;
        tmr_nxt_s        = tmr_r;
        saved_mode_nxt_s = saved_mode_r;
        saved_tmr_nxt_s  = saved_tmr_r;
        mode_change_s    = 1'b0;
        if (power_pellet) begin
            if (mode_r == MODE_FRIGHT) begin
                // Re-arm only; the ghosts are already fleeing, no reversal.
                tmr_nxt_s = '0;
            end else begin
                saved_mode_nxt_s = mode_r;
                saved_tmr_nxt_s  = tmr_r;
                mode_nxt_s       = MODE_FRIGHT;
                tmr_nxt_s        = '0;
                mode_change_s    = 1'b1;
            end
        end else if (frame_tick) begin
            case (mode_r)
                MODE_SCATTER: begin
                    if (tmr_r == SCAT_LAST) begin
                        mode_nxt_s    = MODE_CHASE;
                        tmr_nxt_s     = '0;
                        mode_change_s = 1'b1;
                    end else begin
                        tmr_nxt_s = tmr_r + TMR_W'(1);
                    end
                end
                MODE_CHASE: begin
                    if (tmr_r == CHASE_LAST) begin
                        mode_nxt_s    = MODE_SCATTER;
                        tmr_nxt_s     = '0;
                        mode_change_s = 1'b1;
                    end else begin
                        tmr_nxt_s = tmr_r + TMR_W'(1);
                    end
                end
                MODE_FRIGHT: begin
                    if (tmr_r == FRIGHT_LAST) begin
                        // Resume the interrupted scatter/chase phase where it paused.
                        mode_nxt_s    = saved_mode_r;
                        tmr_nxt_s     = saved_tmr_r;
                        mode_change_s = 1'b1;
                    end else begin
                        tmr_nxt_s = tmr_r + TMR_W'(1);
                    end
                end
                default: begin
                    mode_nxt_s = MODE_SCATTER;
                    tmr_nxt_s  = '0;
                end
            endcase
        end else begin
            mode_change_s = 1'b0;
        end
    end

    // Mode sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r       <= MODE_SCATTER;
            tmr_r        <= '0;
            saved_mode_r <= MODE_SCATTER;
            saved_tmr_r  <= '0;
        end else begin
            mode_r       <= mode_nxt_s;
            tmr_r        <= tmr_nxt_s;
            saved_mode_r <= saved_mode_nxt_s;
            saved_tmr_r  <= saved_tmr_nxt_s;
        end
    end

    // Decision engine for the ghost selected by idx_r.
    always_comb begin
        cur_gx_s = '0;
        cur_gy_s = '0;
        cur_v_s  = 4'b0000;
        cur_p_s  = DIR_LEFT;
        cur_rp_s = 1'b0;
        for (int g = 0; g < NUM_GHOSTS; g++) begin
            cur_gx_s = (idx_r == 3'(g)) ? ghost_pos_x[g*X_W +: X_W]  : cur_gx_s;
            cur_gy_s = (idx_r == 3'(g)) ? ghost_pos_y[g*Y_W +: Y_W]  : cur_gy_s;
            cur_v_s  = (idx_r == 3'(g)) ? valid_moves[g*4 +: 4]      : cur_v_s;
            cur_p_s  = (idx_r == 3'(g)) ? move_direction[g*4 +: 4]   : cur_p_s;
            cur_rp_s = (idx_r == 3'(g)) ? rev_pend_r[g]              : cur_rp_s;
        end

        // Scatter corners: bit0 of the index picks right, bit1 picks bottom.
        tx_s = (mode_r == MODE_CHASE) ? pacman_pos_x : (idx_r[0] ? X_W'(MAX_X) : '0);
        ty_s = (mode_r == MODE_CHASE) ? pacman_pos_y : (idx_r[1] ? Y_W'(MAX_Y) : '0);

        dx_s  = DW'(tx_s) - DW'(cur_gx_s);
        dy_s  = DW'(ty_s) - DW'(cur_gy_s);
        adx_s = dx_s[DW-1] ? DW'(-dx_s) : DW'(dx_s);
        ady_s = dy_s[DW-1] ? DW'(-dy_s) : DW'(dy_s);

        // Screen coordinates: y grows downward.
        dir_x_s = (dx_s == '0) ? 4'b0000 : (dx_s[DW-1] ? DIR_LEFT : DIR_RIGHT);
        dir_y_s = (dy_s == '0) ? 4'b0000 : (dy_s[DW-1] ? DIR_UP : DIR_DOWN);

        // Ties favour the vertical axis.
        prim_s = (adx_s > ady_s) ? dir_x_s : dir_y_s;
        sec_s  = (adx_s > ady_s) ? dir_y_s : dir_x_s;

        rev_s      = reverse_dir(cur_p_s);
        allowed_s  = cur_v_s & ~rev_s;
        next_dir_s = cur_p_s;
        clear_rp_s = 1'b0;

        if (cur_rp_s && ((cur_v_s & rev_s) != 4'b0000)) begin
            next_dir_s = rev_s;
            clear_rp_s = 1'b1;
        end else if (allowed_s == 4'b0000) begin
            // Dead end: turn back if possible, otherwise stay put.
            next_dir_s = ((cur_v_s & rev_s) != 4'b0000) ? rev_s : cur_p_s;
        end else if (mode_r == MODE_FRIGHT) begin
            next_dir_s = fright_pick(allowed_s, lfsr_r[1:0]);
        end else begin
            next_dir_s = target_pick(allowed_s, prim_s, sec_s);
        end
    end

    // Sweep sequencing, per-ghost direction registers, LFSR and reversal flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            move_direction <= {NUM_GHOSTS{DIR_LEFT}};
            busy           <= 1'b0;
            sweep_done     <= 1'b0;
            overrun        <= 1'b0;
            idx_r          <= 3'd0;
            lfsr_r         <= 16'hACE1;
            rev_pend_r     <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (frame_tick && busy) begin
                overrun <= 1'b1;
            end
            if (busy) begin
                for (int g = 0; g < NUM_GHOSTS; g++) begin
                    if (idx_r == 3'(g)) begin
                        move_direction[g*4 +: 4] <= next_dir_s;
                    end
                end
                lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
                if (idx_r == LAST_IDX) begin
                    busy       <= 1'b0;
                    sweep_done <= 1'b1;
                    idx_r      <= 3'd0;
                end else begin
                    idx_r <= idx_r + 3'd1;
                end
            end else if (frame_tick) begin
                busy  <= 1'b1;
                idx_r <= 3'd0;
            end
            // A fresh mode change re-arms every ghost, even the one being cleared.
            if (mode_change_s) begin
                rev_pend_r <= {NUM_GHOSTS{1'b1}};
            end else if (busy && clear_rp_s) begin
                for (int g = 0; g < NUM_GHOSTS; g++) begin
                    if (idx_r == 3'(g)) begin
                        rev_pend_r[g] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ghost_ai_controller.sv
// Testbench for ghost_ai_controller (4 ghosts, default timing).
// Stimulus pushes the expected {mode, directions} for every sweep it starts;
// a monitor pops and compares on each sweep_done pulse.
module tb_ghost_ai_controller;

    localparam int N  = 4;
    localparam int XW = 11;
    localparam int YW = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_tick;
    logic            power_pellet;
    logic [XW-1:0]   pac_x;
    logic [YW-1:0]   pac_y;
    logic [N*XW-1:0] gx;
    logic [N*YW-1:0] gy;
    logic [N*4-1:0]  vm;
    logic [N*4-1:0]  move_direction;
    logic [1:0]      mode;
    logic            busy;
    logic            sweep_done;
    logic            overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_sweeps = 0;
    logic [17:0] sb_q[$];
    logic [15:0] exp16;

    always #5 clk = ~clk;

    ghost_ai_controller #(.NUM_GHOSTS(N), .X_W(XW), .Y_W(YW)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .power_pellet  (power_pellet),
        .pacman_pos_x  (pac_x),
        .pacman_pos_y  (pac_y),
        .ghost_pos_x   (gx),
        .ghost_pos_y   (gy),
        .valid_moves   (vm),
        .move_direction(move_direction),
        .mode          (mode),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .overrun       (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] slot_dir_tb(input logic [1:0] s);
        logic [3:0] d;
        case (s)
            2'd0:    d = 4'b0010;
            2'd1:    d = 4'b1000;
            2'd2:    d = 4'b0100;
            default: d = 4'b0001;
        endcase
        return d;
    endfunction

    // Frightened choice for a ghost evaluated after 'steps' LFSR shifts.
    function automatic logic [3:0] fright_exp(input int steps, input logic [3:0] allowed);
        logic [15:0] l;
        logic [3:0]  d;
        l = 16'hACE1;
        for (int k = 0; k < steps; k++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        for (int k = 0; k < 4; k++) begin
            d = slot_dir_tb(l[1:0] + 2'(k));
            if ((allowed & d) != 4'b0000) return d;
        end
        return 4'b0000;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst && sweep_done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_sweep_done: got pulse, expected none");
            end else begin
                e = sb_q.pop_front();
                check("sweep_dirs", 32'(move_direction), 32'(e[15:0]));
                check("sweep_mode", 32'(mode), 32'(e[17:16]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic do_sweep(input logic [15:0] exp_dirs, input logic [1:0] exp_mode,
                            input logic pellet);
        sb_q.push_back({exp_mode, exp_dirs});
        frame_tick   = 1'b1;
        power_pellet = pellet;
        @(negedge clk);
        frame_tick   = 1'b0;
        power_pellet = 1'b0;
        repeat (5) @(negedge clk);
        n_sweeps++;
    endtask

    task automatic hold_sweeps(input int count, input logic [15:0] exp_dirs,
                               input logic [1:0] exp_mode);
        for (int i = 0; i < count; i++) do_sweep(exp_dirs, exp_mode, 1'b0);
    endtask

    task automatic pulse_pellet(input logic [1:0] exp_mode);
        power_pellet = 1'b1;
        @(negedge clk);
        power_pellet = 1'b0;
        check("mode_after_pellet", 32'(mode), 32'(exp_mode));
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; power_pellet = 1'b0;
        pac_x = '0; pac_y = '0;
        gx = {N{11'd320}}; gy = {N{10'd240}}; vm = 16'hFFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_dirs", 32'(move_direction), 32'h8888);
        check("reset_mode", 32'(mode), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_sweep_done", 32'(sweep_done), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);

        // First sweep in SCATTER from LEFT headings, with cycle-accurate timing.
        sb_q.push_back({2'b00, 16'h4828});
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check("sweep_busy_timing", 32'(busy), (k <= 4) ? 32'h1 : 32'h0);
            check("sweep_done_timing", 32'(sweep_done), (k == 5) ? 32'h1 : 32'h0);
            if (k < 6) @(negedge clk);
        end
        n_sweeps++;

        // Run SCATTER out with no legal moves; directions hold.
        vm = 16'h0000;
        hold_sweeps(418, 16'h4828, 2'b00);

        // 420th tick: CHASE, forced reversal; ghost 2 cannot reverse yet.
        vm = {4'hF, 4'h8, 4'hF, 4'hF};
        do_sweep(16'h2841, 2'b01, 1'b0);

        // Ghost 2's reverse becomes legal; others chase pacman to the right.
        vm = 16'hFFFF;
        gx = {N{11'd100}}; gy = {N{10'd100}};
        pac_x = 11'd300; pac_y = 10'd120;
        do_sweep(16'h1111, 2'b01, 1'b0);
        pac_x = 11'd110; pac_y = 10'd300;
        do_sweep(16'h4444, 2'b01, 1'b0);
        pac_x = 11'd150; pac_y = 10'd150;       // tie -> vertical
        do_sweep(16'h4444, 2'b01, 1'b0);
        pac_x = 11'd100; pac_y = 10'd50;        // UP blocked, dx=0 -> fallback LEFT
        do_sweep(16'h8888, 2'b01, 1'b0);
        pac_x = 11'd100; pac_y = 10'd0;
        do_sweep(16'h2222, 2'b01, 1'b0);
        vm = 16'h0000;                          // boxed in: hold UP
        do_sweep(16'h2222, 2'b01, 1'b0);
        vm = 16'h4444;                          // corridor: only DOWN
        do_sweep(16'h4444, 2'b01, 1'b0);

        // CHASE timer to 500, then pellet.
        vm = 16'h0000;
        hold_sweeps(493, 16'h4444, 2'b01);
        pulse_pellet(2'b10);

        vm = 16'hFFFF;                          // pending reversal: DOWN -> UP
        do_sweep(16'h2222, 2'b10, 1'b0);
        exp16 = '0;
        for (int i = 0; i < N; i++) exp16[i*4 +: 4] = fright_exp(4 * n_sweeps + i, 4'b1011);
        do_sweep(exp16, 2'b10, 1'b0);
        vm = 16'h4444;
        do_sweep(16'h4444, 2'b10, 1'b0);

        // Fright timer to 200, pellet re-arms without reversal.
        vm = 16'h0000;
        hold_sweeps(197, 16'h4444, 2'b10);
        pulse_pellet(2'b10);
        vm = 16'h6666;                          // UP is legal but must not be taken
        do_sweep(16'h4444, 2'b10, 1'b0);
        vm = 16'h0000;
        hold_sweeps(358, 16'h4444, 2'b10);

        // 360th tick after re-arm: back to CHASE with reversal.
        vm = 16'hFFFF;
        do_sweep(16'h2222, 2'b01, 1'b0);

        // Restored timer 500: CHASE for 699 more ticks, SCATTER on the 700th.
        vm = 16'h0000;
        hold_sweeps(699, 16'h2222, 2'b01);
        do_sweep(16'h2222, 2'b00, 1'b0);
        hold_sweeps(419, 16'h2222, 2'b00);
        do_sweep(16'h2222, 2'b10, 1'b1);       // expiry + pellet: pellet wins

        // Overrun: second tick on cycle 2 of the sweep.
        sb_q.push_back({2'b10, 16'h2222});
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("busy_at_second_tick", 32'(busy), 32'h1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("overrun_set", 32'(overrun), 32'h1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check("no_second_sweep", 32'(busy), 32'h0);
            @(negedge clk);
        end
        check("overrun_sticky", 32'(overrun), 32'h1);

        // Reset in the middle of a sweep.
        vm = 16'hFFFF;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_dirs", 32'(move_direction), 32'h8888);
        check("midrst_mode", 32'(mode), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        for (int k = 0; k < 6; k++) begin
            check("midrst_no_sweep_done", 32'(sweep_done), 32'h0);
            @(negedge clk);
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ghost_ai_controller.md
Name: ghost_ai_controller

Overview:
- Parametrised multi-ghost direction controller. Replaces per-ghost combinational chasers with one shared, time-multiplexed decision engine.
- Adds a global SCATTER/CHASE/FRIGHTENED mode FSM with frame-based timers, forced reversal on mode change, LFSR-driven frightened wandering, and per-ghost registered directions.
- Sits between the per-ghost valid_move_detector instances and the ghost position updaters.

Parameters:
- NUM_GHOSTS, 4, number of ghosts served; 1..8.
- X_W, 11, horizontal position width.
- Y_W, 10, vertical position width.
- MAX_X, 639, right scatter-corner x.
- MAX_Y, 479, bottom scatter-corner y.
- SCATTER_FRAMES, 420, frame ticks spent in SCATTER.
- CHASE_FRAMES, 1200, frame ticks spent in CHASE.
- FRIGHT_FRAMES, 360, frame ticks spent in FRIGHTENED.
- TMR_W, 12, mode timer width; must hold the largest *_FRAMES value.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per game frame.
- power_pellet  in  1  one-cycle pulse when pacman eats a power pellet.
- pacman_pos_x  in  X_W  pacman x.
- pacman_pos_y  in  Y_W  pacman y.
- ghost_pos_x  in  NUM_GHOSTS*X_W  packed ghost x; ghost i at slice i.
- ghost_pos_y  in  NUM_GHOSTS*Y_W  packed ghost y.
- valid_moves  in  NUM_GHOSTS*4  per-ghost legal directions from the detectors.
- move_direction  out  NUM_GHOSTS*4  registered one-hot direction per ghost.
- mode  out  2  00 SCATTER, 01 CHASE, 10 FRIGHTENED.
- busy  out  1  decision sweep in progress.
- sweep_done  out  1  one-cycle pulse after the last ghost is updated.
- overrun  out  1  sticky; frame_tick arrived while busy.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; port names are clk and rst.
- Direction encoding: RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000. reverse(d) swaps RIGHT/LEFT and UP/DOWN.
- Reset values:
  - every move_direction slice = LEFT; mode = SCATTER; mode timer = 0; saved mode/timer = SCATTER/0.
  - busy = 0, sweep_done = 0, overrun = 0.
  - LFSR = 16'hACE1; all reverse_pending flags = 0.
- Mode FSM, advanced only on frame_tick:
  - SCATTER: timer increments; at SCATTER_FRAMES-1, go to CHASE with timer 0.
  - CHASE: timer increments; at CHASE_FRAMES-1, go to SCATTER with timer 0.
  - FRIGHTENED: timer increments; at FRIGHT_FRAMES-1, return to the saved mode and saved timer.
- power_pellet:
  - From SCATTER/CHASE: save mode and timer, enter FRIGHTENED with timer 0.
  - While already FRIGHTENED: reload timer to 0, no reversal.
  - Same cycle as a timer expiry: pellet wins.
- Any mode change (including FRIGHTENED exit) sets reverse_pending for all ghosts.
- Sweep:
  - frame_tick while idle: busy=1 next cycle; ghost index steps 0..NUM_GHOSTS-1, one ghost per cycle.
  - Ghost i's inputs are sampled in its evaluation cycle; move_direction[i] updates at the end of that cycle.
  - After the last ghost: busy=0 and sweep_done=1 for one cycle.
  - Latency from frame_tick to sweep_done is NUM_GHOSTS+1 cycles.
  - frame_tick while busy: timers still advance, no new sweep starts, overrun set (cleared only by rst).
- Per-ghost decision, with p = current direction and v = valid_moves[i]:
  1. If reverse_pending[i] and v has reverse(p): choose reverse(p), clear the flag. If the reverse is invalid, the flag stays set.
  2. Otherwise allowed = v & ~reverse(p). If allowed == 0: choose reverse(p) if valid, else hold p.
  3. FRIGHTENED: LFSR[1:0] picks a start slot in the order UP, LEFT, DOWN, RIGHT; take the first allowed direction rotating from that slot.
  4. SCATTER/CHASE target:
     - CHASE: pacman position.
     - SCATTER: x = MAX_X if bit0 of i is set, else 0; y = MAX_Y if bit1 of i is set, else 0.
  5. Distances: dx = tx - gx, dy = ty - gy, signed with one guard bit. Primary axis is the one with larger |d|; a tie goes vertical.
  6. Choice order, first allowed wins:
     - primary-axis direction toward the target, if its distance is nonzero;
     - secondary-axis direction toward the target, if its distance is nonzero;
     - UP, LEFT, DOWN, RIGHT.
- LFSR: x^16+x^14+x^13+x^11, steps once per evaluation cycle.
- rst mid-sweep: the sweep aborts and all state returns to reset values. No sweep_done pulse is issued.

Test Plan:
- Reset, then one frame_tick with NUM_GHOSTS=4: busy high for 4 cycles, sweep_done pulses 5 cycles after the tick; all slices decided from LEFT heading.
- CHASE, ghost (100,100) heading RIGHT, pacman (300,120), v=1111 -> RIGHT; pacman (110,300) -> DOWN; dx=dy=50 -> DOWN (tie goes vertical).
- Corridor: heading UP, v=0100 (DOWN only) -> DOWN; v=0000 -> holds UP.
- Drive 420 frame_ticks -> mode 00->01 on the 420th. Next sweep: ghosts heading RIGHT with v including LEFT turn LEFT. A ghost whose reverse is blocked reverses on the first sweep where it becomes legal.
- power_pellet at CHASE timer 500 -> mode 10. Pellet again at fright timer 200 -> timer reloads, no reversal. 360 ticks later -> mode 01 with timer 500 restored.
- frame_tick on cycle 2 of a sweep -> overrun=1, no second sweep. Same cycle as expiry, power_pellet -> mode 10. rst mid-sweep -> no sweep_done; all slices LEFT.
